serial_sub: RTL and testbench

Bit-serial 4-bit unsigned subtractor computing D = X − Y, one bit per clock from LSB to MSB, with a start/busy/done handshake. It is the inverse-direction companion to the team's combinational 4-bit adder `sum`. It uses the same per-bit port convention: index 0 is the MSB and index 3 is the LSB. Its final borrow flags X < Y. It sits beside `sum` in the arithmetic datapath wherever a subtraction or magnitude compare is needed and one result per six cycles is acceptable.

---
 rtl/serial_sub_if.sv | 39 +++
 rtl/serial_sub.sv | 128 ++++++++++++
 tb/tb_serial_sub.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/serial_sub_if.sv
// rtl/serial_sub_if.sv - operand/result/handshake bundle for the bit-serial subtractor
interface serial_sub_if;
    logic start;
    logic x0;
    logic x1;
    logic x2;
    logic x3;
    logic y0;
    logic y1;
    logic y2;
    logic y3;
    logic d0;
    logic d1;
    logic d2;
    logic d3;
    logic borrow;
    logic busy;
    logic done;

    modport master (
        output start,
        output x0, x1, x2, x3,
        output y0, y1, y2, y3,
        input  d0, d1, d2, d3,
        input  borrow,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  x0, x1, x2, x3,
        input  y0, y1, y2, y3,
        output d0, d1, d2, d3,
        output borrow,
        output busy,
        output done
    );
endinterface

// File: rtl/serial_sub.sv
// rtl/serial_sub.sv - bit-serial 4-bit unsigned subtractor, LSB first, start/busy/done handshake
module serial_sub (
    input  logic         clk,
    input  logic         rst_n,
    serial_sub_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Vectors below are indexed like the ports: bit 0 is the MSB, bit 3 the LSB.
    state_t     state;
    state_t     state_next;
    logic [1:0] cnt;
    logic [1:0] cnt_next;
    logic       bw;
    logic       bw_next;
    logic [3:0] xr;
    logic [3:0] xr_next;
    logic [3:0] yr;
    logic [3:0] yr_next;
    logic [3:0] diff;
    logic [3:0] diff_next;
    logic [3:0] d_r;
    logic [3:0] d_next;
    logic       borrow_r;
    logic       borrow_next;
    logic       busy_r;
    logic       busy_next;
    logic       done_r;
    logic       done_next;

    logic       a;
    logic       b;
    logic       bit_diff;
    logic       bit_borrow;

    // One full-subtractor step on the operand bit currently selected by cnt.
    always_comb begin
        a          = xr[cnt];
        b          = yr[cnt];
        bit_diff   = a ^ b ^ bw;
        bit_borrow = (~a & b) | (~(a ^ b) & bw);
    end

    // Next-state and datapath updates; results commit only on the edge entering DONE.
    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        bw_next     = bw;
        xr_next     = xr;
        yr_next     = yr;
        diff_next   = diff;
        d_next      = d_r;
        borrow_next = borrow_r;

        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    xr_next    = {bus.x3, bus.x2, bus.x1, bus.x0};
                    yr_next    = {bus.y3, bus.y2, bus.y1, bus.y0};
                    bw_next    = 1'b0;
                    cnt_next   = 2'd3;
                    state_next = RUN;
                end
            end
            RUN: begin
                diff_next[cnt] = bit_diff;
                bw_next        = bit_borrow;
                if (cnt == 2'd0) begin
                    // The MSB is produced on this same edge, so commit it straight
                    // from the step logic rather than from the diff register.
                    d_next      = {diff[3:1], bit_diff};
                    borrow_next = bit_borrow;
                    state_next  = DONE;
                end else begin
                    cnt_next = cnt - 2'd1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        busy_next = (state_next == RUN);
        done_next = (state_next == DONE);
    end

    // State and datapath registers; reset wins over start on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= 2'd3;
            bw       <= 1'b0;
            xr       <= 4'd0;
            yr       <= 4'd0;
            diff     <= 4'd0;
            d_r      <= 4'd0;
            borrow_r <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            bw       <= bw_next;
            xr       <= xr_next;
            yr       <= yr_next;
            diff     <= diff_next;
            d_r      <= d_next;
            borrow_r <= borrow_next;
            busy_r   <= busy_next;
            done_r   <= done_next;
        end
    end

    assign bus.d0     = d_r[0];
    assign bus.d1     = d_r[1];
    assign bus.d2     = d_r[2];
    assign bus.d3     = d_r[3];
    assign bus.borrow = borrow_r;
    assign bus.busy   = busy_r;
    assign bus.done   = done_r;
endmodule

// File: tb/tb_serial_sub.sv
// tb/tb_serial_sub.sv - scoreboard bench for serial_sub
module tb_serial_sub;
    logic clk;
    logic rst_n;
    serial_sub_if bus();

    serial_sub dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         errors   = 0;
    int         checks   = 0;
    int         done_cnt = 0;
    int         exp_done = 0;
    logic [4:0] sb[$];
    logic [4:0] held     = 5'd0;
    bit         last_rst = 1'b0;

    typedef struct {
        logic [3:0] x;
        logic [3:0] y;
        logic [4:0] exp;
    } vec_t;

    function automatic logic [4:0] outv();
        return {bus.d0, bus.d1, bus.d2, bus.d3, bus.borrow};
    endfunction

    task automatic set_ops(input logic [3:0] x, input logic [3:0] y);
        bus.x0 = x[3]; bus.x1 = x[2]; bus.x2 = x[1]; bus.x3 = x[0];
        bus.y0 = y[3]; bus.y1 = y[2]; bus.y2 = y[1]; bus.y3 = y[0];
    endtask

    task automatic rand_ops();
        set_ops(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    endtask

    task automatic push_exp(input logic [4:0] e);
        sb.push_back(e);
        exp_done++;
    endtask

    function automatic logic [4:0] model(input logic [3:0] x, input logic [3:0] y);
        logic [3:0] dd;
        dd = x - y;
        return {dd, (x < y)};
    endfunction

    task automatic chk(input string name, input logic [4:0] act, input logic [4:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, req);
        end
    endtask

    // Remember whether the most recent edge was a reset edge.
    always @(posedge clk) last_rst = rst_n;

    // Monitor: pops the scoreboard on every done pulse, otherwise checks results hold.
    always @(negedge clk) begin
        if (!last_rst) begin
            held = 5'd0;
            chk("reset_outputs", {outv(), bus.busy, bus.done}, 7'd0);
        end else begin
            chk("busy_done_overlap", {4'd0, bus.busy & bus.done}, 5'd0);
            if (bus.done) begin
                done_cnt++;
                if (sb.size() == 0) begin
                    chk("unexpected_done", outv(), 5'bxxxxx);
                end else begin
                    held = sb.pop_front();
                    chk("result", outv(), held);
                end
            end else begin
                chk("result_hold", outv(), held);
            end
        end
    end

    // Start an operation now (away from the edge); returns just after E0.
    task automatic start_op(input logic [3:0] x, input logic [3:0] y, input logic [4:0] e);
        bus.start = 1'b1;
        set_ops(x, y);
        push_exp(e);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Directed operation with cycle-exact busy/done checks; returns after E5 sampling.
    task automatic timed_op(input logic [3:0] x, input logic [3:0] y, input logic [4:0] e);
        start_op(x, y, e);
        rand_ops();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("busy_phase", {3'd0, bus.busy, bus.done}, 5'b00010);
            rand_ops();
        end
        @(negedge clk);
        chk("done_phase", {3'd0, bus.busy, bus.done}, 5'b00001);
        @(negedge clk);
        chk("idle_phase", {3'd0, bus.busy, bus.done}, 5'b00000);
    endtask

    vec_t dir[4];

    initial begin
        dir[0] = '{x: 4'd5, y: 4'd3,  exp: 5'b0010_0};
        dir[1] = '{x: 4'd3, y: 4'd5,  exp: 5'b1110_1};
        dir[2] = '{x: 4'd0, y: 4'd15, exp: 5'b0001_1};
        dir[3] = '{x: 4'd9, y: 4'd9,  exp: 5'b0000_0};

        // Reset held for two edges with start asserted.
        rst_n     = 1'b0;
        bus.start = 1'b1;
        rand_ops();
        @(posedge clk);
        #1 rand_ops();
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        bus.start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_after_reset", {3'd0, bus.busy, bus.done}, 5'd0);
        end

        // Directed vectors with full latency checking.
        foreach (dir[i]) timed_op(dir[i].x, dir[i].y, dir[i].exp);

        // Exhaustive pairs at the minimum 6-cycle start interval.
        @(posedge clk);
        #1;
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                start_op(4'(x), 4'(y), model(4'(x), 4'(y)));
                rand_ops();
                bus.start = 1'b0;
                repeat (5) begin
                    @(posedge clk);
                    #1 rand_ops();
                end
            end
        end
        repeat (2) @(posedge clk);
        #1;

        // start held high from E0 through E5 with changing operands; only E0 and E6 count.
        bus.start = 1'b1;
        set_ops(4'd12, 4'd7);
        push_exp(5'b0101_0);
        @(posedge clk);
        for (int k = 1; k <= 5; k++) begin
            #1;
            bus.start = 1'b1;
            rand_ops();
            @(posedge clk);
        end
        #1;
        bus.start = 1'b1;
        set_ops(4'd2, 4'd6);
        push_exp(5'b1100_1);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (7) @(posedge clk);
        #1;

        // Reset on E2 aborts the operation; a fresh start then completes normally.
        start_op(4'd15, 4'd1, 5'b1110_0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        void'(sb.pop_back());
        exp_done--;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("idle_after_abort", {3'd0, bus.busy, bus.done}, 5'd0);
        timed_op(4'd15, 4'd1, 5'b1110_0);

        // Drain with a bounded wait.
        for (int t = 0; t < 50 && sb.size() != 0; t++) @(posedge clk);
        repeat (2) @(posedge clk);
        chk("scoreboard_drained", 5'(sb.size()), 5'd0);
        checks++;
        if (done_cnt != exp_done) begin
            errors++;
            $display("FAIL done_count: got %0d expected %0d", done_cnt, exp_done);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
